// File: rtl/up_down_counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// Covers direction/mode encodings, the MAX_VAL derivation and parameter legality.
package up_down_counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   function automatic int calc_max_val(input int modulo);
      return modulo - 1;
   endfunction

   function automatic bit params_legal(input int width, input int modulo);
      return (width >= 1) && (width <= 16) && (modulo >= 2) && (modulo <= (1 << width));
   endfunction

endpackage

// File: rtl/up_down_counter_next.sv
// Combinational next-count logic: step up/down, wrap modulo MODULO or saturate.
// Zero latency; flags report a wrap in either direction or a step blocked at a bound.
module up_down_counter_next
   import up_down_counter_pkg::*;
#(
   parameter int WIDTH  = 3,
   parameter int MODULO = 2 ** WIDTH
) (
   input  logic [WIDTH-1:0] cur,
   input  logic             dir,
   input  logic             sat,
   output logic [WIDTH-1:0] next_out,
   output logic             wrap_up,
   output logic             wrap_down,
   output logic             blocked
);

   localparam int             MAX_VAL = calc_max_val(MODULO);
   localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);

   // One extra bit keeps cur+1 from overflowing when MAX_VAL is all ones.
   logic [WIDTH:0] w_cur_ext;
   logic [WIDTH:0] w_inc;
   logic [WIDTH:0] w_dec;
   logic           w_at_max;
   logic           w_at_zero;

   assign w_cur_ext = {1'b0, cur};
   assign w_inc     = w_cur_ext + (WIDTH+1)'(1);
   assign w_dec     = w_cur_ext - (WIDTH+1)'(1);
   assign w_at_max  = (w_cur_ext == MAX_EXT);
   assign w_at_zero = (w_cur_ext == '0);

   always_comb begin
      next_out  = cur;
      wrap_up   = 1'b0;
      wrap_down = 1'b0;
      blocked   = 1'b0;
      if (dir == DIR_UP) begin
         if (!w_at_max) begin
            next_out = w_inc[WIDTH-1:0];
         end else if (sat == MODE_SAT) begin
            blocked = 1'b1;
         end else begin
            next_out = '0;
            wrap_up  = 1'b1;
         end
      end else begin
         if (!w_at_zero) begin
            next_out = w_dec[WIDTH-1:0];
         end else if (sat == MODE_SAT) begin
            blocked = 1'b1;
         end else begin
            next_out  = MAX_EXT[WIDTH-1:0];
            wrap_down = 1'b1;
         end
      end
   end

endmodule

// File: rtl/up_down_counter_mod.sv
// Up/down modulo counter with load, wrap/saturate and registered carry/borrow; 1-cycle latency.
// Optional sticky overflow flag (ports ovf_clr/ovf) under UPDOWN_CNT_STICKY_OVF_EN.
module up_down_counter_mod
   import up_down_counter_pkg::*;
#(
   parameter int WIDTH  = 3,
   parameter int MODULO = 2 ** WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld,
   input  logic [WIDTH-1:0] data,
   input  logic             en,
   input  logic             dir,
   input  logic             sat,
`ifdef UPDOWN_CNT_STICKY_OVF_EN
   input  logic             ovf_clr,
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             borrow,
   output logic             at_max,
   output logic             at_min
);

   localparam int             MAX_VAL = calc_max_val(MODULO);
   localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);

   if (!params_legal(WIDTH, MODULO)) begin : g_bad_params
      $fatal(1, "up_down_counter_mod: illegal WIDTH/MODULO");
   end

   logic [WIDTH-1:0] r_out;
   logic             r_carry;
   logic             r_borrow;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_ld_val;
   logic             w_wrap_up;
   logic             w_wrap_down;
   logic             w_blocked;

   up_down_counter_next #(.WIDTH(WIDTH), .MODULO(MODULO)) u_next (
      .cur       (r_out),
      .dir       (dir),
      .sat       (sat),
      .next_out  (w_next),
      .wrap_up   (w_wrap_up),
      .wrap_down (w_wrap_down),
      .blocked   (w_blocked)
   );

   assign w_ld_val = ({1'b0, data} > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : data;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_out    <= '0;
         r_carry  <= 1'b0;
         r_borrow <= 1'b0;
      end else if (ld) begin
         r_out    <= w_ld_val;
         r_carry  <= 1'b0;
         r_borrow <= 1'b0;
      end else if (en) begin
         r_out    <= w_next;
         r_carry  <= w_wrap_up;
         r_borrow <= w_wrap_down;
      end else begin
         r_carry  <= 1'b0;
         r_borrow <= 1'b0;
      end
   end

`ifdef UPDOWN_CNT_STICKY_OVF_EN
   logic r_ovf;
   logic w_ovf_set;

   // Set wins over clear when both happen on the same edge.
   assign w_ovf_set = !ld && en && (w_wrap_up || w_wrap_down || w_blocked);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign ovf = r_ovf;
`else
   logic w_unused_blocked;
   assign w_unused_blocked = w_blocked;
`endif

   assign out    = r_out;
   assign carry  = r_carry;
   assign borrow = r_borrow;
   assign at_max = ({1'b0, r_out} == MAX_EXT);
   assign at_min = (r_out == '0);

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Directed bench for up_down_counter_mod across MODULO 8, 6 and 16 instances.
// Sticky-overflow checks are included when UPDOWN_CNT_STICKY_OVF_EN is defined.
module tb_up_down_counter_mod;

   logic       clk = 1'b0;
   logic       reset;
   logic       ld;
   logic [3:0] data;
   logic       en;
   logic       dir;
   logic       sat;
   logic       ovf_clr;

   logic [2:0] out8, out6;
   logic [3:0] out16;
   logic       carry8, borrow8, at_max8, at_min8;
   logic       carry6, borrow6, at_max6, at_min6;
   logic       carry16, borrow16, at_max16, at_min16;
   logic       ovf8, ovf6, ovf16;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   up_down_counter_mod #(.WIDTH(3), .MODULO(8)) u_dut8 (
      .clk(clk), .reset(reset), .ld(ld), .data(data[2:0]), .en(en), .dir(dir), .sat(sat),
`ifdef UPDOWN_CNT_STICKY_OVF_EN
      .ovf_clr(ovf_clr), .ovf(ovf8),
`endif
      .out(out8), .carry(carry8), .borrow(borrow8), .at_max(at_max8), .at_min(at_min8)
   );

   up_down_counter_mod #(.WIDTH(3), .MODULO(6)) u_dut6 (
      .clk(clk), .reset(reset), .ld(ld), .data(data[2:0]), .en(en), .dir(dir), .sat(sat),
`ifdef UPDOWN_CNT_STICKY_OVF_EN
      .ovf_clr(ovf_clr), .ovf(ovf6),
`endif
      .out(out6), .carry(carry6), .borrow(borrow6), .at_max(at_max6), .at_min(at_min6)
   );

   up_down_counter_mod #(.WIDTH(4), .MODULO(16)) u_dut16 (
      .clk(clk), .reset(reset), .ld(ld), .data(data), .en(en), .dir(dir), .sat(sat),
`ifdef UPDOWN_CNT_STICKY_OVF_EN
      .ovf_clr(ovf_clr), .ovf(ovf16),
`endif
      .out(out16), .carry(carry16), .borrow(borrow16), .at_max(at_max16), .at_min(at_min16)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Advance one edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_out [4];
      int exp_brw [4];
      reset = 1'b0; ld = 1'b0; data = '0; en = 1'b0; dir = 1'b1; sat = 1'b0; ovf_clr = 1'b0;
      #2;
      tick();
      check("rst_out8", out8, 0);
      check("rst_carry8", carry8, 0);
      check("rst_borrow8", borrow8, 0);
      check("rst_at_min8", at_min8, 1);
      check("rst_at_max8", at_max8, 0);
`ifdef UPDOWN_CNT_STICKY_OVF_EN
      check("rst_ovf8", ovf8, 0);
`endif

      // Free-run up on MODULO 8: 1..7,0,1 with carry only on the wrap.
      reset = 1'b1; en = 1'b1; dir = 1'b1; sat = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         check($sformatf("up8_out[%0d]", i), out8, (i + 1) % 8);
         check($sformatf("up8_carry[%0d]", i), carry8, (i == 7) ? 1 : 0);
         check($sformatf("up8_at_max[%0d]", i), at_max8, (i == 6) ? 1 : 0);
      end

      // MODULO 6: load 2 then count down 1,0,5,4 with borrow on 0->5.
      en = 1'b0; ld = 1'b1; data = 4'd2;
      tick();
      check("ld6_out", out6, 2);
      exp_out = '{1, 0, 5, 4};
      exp_brw = '{0, 0, 1, 0};
      ld = 1'b0; en = 1'b1; dir = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("dn6_out[%0d]", i), out6, exp_out[i]);
         check($sformatf("dn6_borrow[%0d]", i), borrow6, exp_brw[i]);
         check($sformatf("dn6_carry[%0d]", i), carry6, 0);
      end
      en = 1'b0; ld = 1'b1; data = 4'd7;
      tick();
      check("clamp6_out", out6, 5);
      check("clamp6_at_max", at_max6, 1);

      // MODULO 16 saturate up from 14 and down from 1.
      data = 4'd14;
      tick();
      check("ld16_out", out16, 14);
      ld = 1'b0; en = 1'b1; sat = 1'b1; dir = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("satup16_out[%0d]", i), out16, 15);
         check($sformatf("satup16_carry[%0d]", i), carry16, 0);
      end
      ld = 1'b1; en = 1'b0; data = 4'd1;
      tick();
      ld = 1'b0; en = 1'b1; dir = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("satdn16_out[%0d]", i), out16, 0);
         check($sformatf("satdn16_borrow[%0d]", i), borrow16, 0);
         check($sformatf("satdn16_at_min[%0d]", i), at_min16, 1);
      end

      // Priority: ld over en, reset over ld.
      sat = 1'b0; en = 1'b0; ld = 1'b1; data = 4'd7;
      tick();
      check("prio_pre_out8", out8, 7);
      en = 1'b1; dir = 1'b1; data = 4'd3;
      tick();
      check("prio_ld_out8", out8, 3);
      check("prio_ld_carry8", carry8, 0);
      reset = 1'b0; data = 4'd5;
      tick();
      check("prio_rst_out8", out8, 0);

      // Down-wrap on MODULO 8, then pulse drops when idle.
      reset = 1'b1; ld = 1'b1; data = 4'd0; en = 1'b0;
      tick();
      ld = 1'b0; en = 1'b1; dir = 1'b0;
      tick();
      check("dn8_out", out8, 7);
      check("dn8_borrow", borrow8, 1);
      check("dn8_carry", carry8, 0);
      en = 1'b0;
      tick();
      check("idle8_out", out8, 7);
      check("idle8_borrow", borrow8, 0);

      // Reset landing on the 7->0 wrap edge clears the carry too.
      en = 1'b1; dir = 1'b1; reset = 1'b0;
      tick();
      check("rstwrap_out8", out8, 0);
      check("rstwrap_carry8", carry8, 0);
      reset = 1'b1;
      tick();
      check("resume_out8", out8, 1);
      check("resume_carry8", carry8, 0);

`ifdef UPDOWN_CNT_STICKY_OVF_EN
      en = 1'b0; ld = 1'b1; data = 4'd7;
      tick();
      check("ovf_pre", ovf8, 0);
      ld = 1'b0; en = 1'b1; dir = 1'b1;
      tick();
      check("ovf_wrap_carry", carry8, 1);
      check("ovf_set", ovf8, 1);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("ovf_hold[%0d]", i), ovf8, 1);
      end
      ld = 1'b1; data = 4'd7;
      tick();
      ld = 1'b0; en = 1'b1; ovf_clr = 1'b1;
      tick();
      check("ovf_set_wins", ovf8, 1);
      en = 1'b0;
      tick();
      check("ovf_clr", ovf8, 0);
      ovf_clr = 1'b0; ld = 1'b1; data = 4'd7;
      tick();
      ld = 1'b0; en = 1'b1; sat = 1'b1;
      tick();
      check("ovf_sat_out", out8, 7);
      check("ovf_sat_block", ovf8, 1);
      en = 1'b0; sat = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
